// File: rtl/des_result_fifo.sv
// rtl/des_result_fifo.sv - show-ahead result FIFO for the DES core output stream
// Captures blocks without backpressure, flags almost-full, counts dropped blocks.
module des_result_fifo #(
  parameter int DEPTH     = 32,
  parameter int AF_MARGIN = 17,
  parameter int DROP_W    = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_dv,
  input  logic [63:0]                i_data,
  output logic                       o_valid,
  output logic [63:0]                o_data,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_almost_full,
  output logic                       o_overflow,
  output logic [DROP_W-1:0]          o_drop_cnt,
  input  logic                       i_clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [63:0]       mem [DEPTH];
  logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic empty, full, rd_fire, wr_en, drop;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    rd_fire = !empty && i_ready;
    // A read in the same cycle frees the slot, so a write into a full FIFO survives.
    wr_en   = i_dv && (!full || rd_fire);
    drop    = i_dv && full && !rd_fire;

    wr_ptr_d = wr_en   ? wr_ptr_q + CW'(1) : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + CW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(rd_fire);
    af_d     = (count_d >= AF_LEVEL);

    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = i_clr_ovf ? DROP_W'(1) : ((drop_q == DROP_MAX) ? drop_q : drop_q + DROP_W'(1));
    end else if (i_clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= i_data;
    end
  end

  assign o_valid       = !empty;
  assign o_data        = mem[rd_ptr_q[AW-1:0]];
  assign o_count       = count_q;
  assign o_almost_full = af_q;
  assign o_overflow    = ovf_q;
  assign o_drop_cnt    = drop_q;

endmodule

// File: tb/tb_des_result_fifo.sv
// tb/tb_des_result_fifo.sv - directed self-checking bench for des_result_fifo
module tb_des_result_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dv;
  logic [63:0] data;
  logic        valid;
  logic [63:0] q;
  logic        ready;
  logic [5:0]  count;
  logic        af;
  logic        ovf;
  logic [15:0] drop_cnt;
  logic        clr;

  int checks = 0;
  int errors = 0;

  logic [63:0] kat [4];
  logic [63:0] exp_d;

  always #5 clk = ~clk;

  des_result_fifo #(.DEPTH(32), .AF_MARGIN(17), .DROP_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dv(dv), .i_data(data),
    .o_valid(valid), .o_data(q), .i_ready(ready), .o_count(count),
    .o_almost_full(af), .o_overflow(ovf), .o_drop_cnt(drop_cnt), .i_clr_ovf(clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    kat[0] = 64'h85E813540F0AB405;
    kat[1] = 64'h8CA64DE9C1B123A7;
    kat[2] = 64'hA0F5C4A82B0C3F2E;
    kat[3] = 64'h95A8D72813DAA94D;
    rst_n = 1'b0; dv = 1'b0; data = '0; ready = 1'b0; clr = 1'b0;
    step(); step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_af", 64'(af), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    step();

    // Five writes, then read them back in order
    for (int i = 1; i <= 5; i++) begin
      dv = 1'b1; data = 64'(i); step();
    end
    dv = 1'b0;
    chk("w5_count", 64'(count), 64'd5);
    chk("w5_valid", 64'(valid), 64'd1);
    chk("w5_data", q, 64'd1);
    ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("r5_data", q, 64'(i));
      step();
    end
    ready = 1'b0;
    chk("r5_valid", 64'(valid), 64'd0);
    chk("r5_count", 64'(count), 64'd0);

    // Almost-full threshold at 15 entries
    for (int i = 1; i <= 15; i++) begin
      dv = 1'b1; data = 64'(100 + i); step();
      if (i == 14) chk("af_at14", 64'(af), 64'd0);
    end
    dv = 1'b0;
    chk("af_at15", 64'(af), 64'd1);
    ready = 1'b1; step(); ready = 1'b0;
    chk("af_after_read", 64'(af), 64'd0);
    chk("af_count14", 64'(count), 64'd14);
    ready = 1'b1;
    for (int i = 0; i < 14; i++) step();
    ready = 1'b0;
    chk("af_drained", 64'(count), 64'd0);

    // Fill, overflow by three, clear
    for (int i = 1; i <= 32; i++) begin
      dv = 1'b1; data = 64'h1000 + 64'(i); step();
    end
    for (int i = 0; i < 3; i++) begin
      dv = 1'b1; data = 64'hDEAD_0000 + 64'(i); step();
    end
    dv = 1'b0;
    chk("ovf_count", 64'(count), 64'd32);
    chk("ovf_flag", 64'(ovf), 64'd1);
    chk("ovf_drop3", 64'(drop_cnt), 64'd3);
    chk("ovf_head", q, 64'h1001);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_ovf", 64'(ovf), 64'd0);
    chk("clr_drop", 64'(drop_cnt), 64'd0);
    chk("clr_count", 64'(count), 64'd32);
    dv = 1'b1; clr = 1'b1; data = 64'hBAD; step();
    dv = 1'b0;
    chk("clr_drop_wins_ovf", 64'(ovf), 64'd1);
    chk("clr_drop_wins_cnt", 64'(drop_cnt), 64'd1);
    step(); clr = 1'b0;
    chk("clr2_drop", 64'(drop_cnt), 64'd0);

    // Full with simultaneous read and write for 10 cycles
    for (int j = 0; j < 10; j++) begin
      chk("full_rw_data", q, 64'h1001 + 64'(j));
      dv = 1'b1; ready = 1'b1; data = 64'h2000 + 64'(j); step();
      chk("full_rw_count", 64'(count), 64'd32);
    end
    dv = 1'b0;
    chk("full_rw_drop", 64'(drop_cnt), 64'd0);
    for (int k = 0; k < 32; k++) begin
      exp_d = (k < 22) ? 64'h100B + 64'(k) : 64'h2000 + 64'(k - 22);
      chk("drain_data", q, exp_d);
      step();
    end
    ready = 1'b0;
    chk("drain_empty", 64'(valid), 64'd0);

    // Back-to-back stream from empty
    ready = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      exp_d = kat[t % 4] ^ 64'(t);
      dv = 1'b1; data = exp_d; step();
      chk("stream_data", q, exp_d);
      chk("stream_count", 64'(count), 64'd1);
    end
    dv = 1'b0; step();
    ready = 1'b0;
    chk("stream_end_valid", 64'(valid), 64'd0);

    // Seven entries stored with overflow flagged, then asynchronous reset
    for (int i = 1; i <= 33; i++) begin
      dv = 1'b1; data = 64'h3000 + 64'(i); step();
    end
    dv = 1'b0; ready = 1'b1;
    for (int i = 0; i < 25; i++) step();
    ready = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd7);
    chk("pre_rst_ovf", 64'(ovf), 64'd1);
    chk("pre_rst_data", q, 64'h301A);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_ovf", 64'(ovf), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    #3 rst_n = 1'b1;
    step();
    dv = 1'b1; data = 64'hABC0_0001; step();
    dv = 1'b1; data = 64'hABC0_0002; step();
    dv = 1'b0;
    chk("post_rst_data", q, 64'hABC0_0001);
    chk("post_rst_count", 64'(count), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
